mstage_lsu: RTL and testbench
=============================

# mstage_lsu

- Memory-access stage that consumes the registered execute-to-memory bundle through the `s_valid`/`s_ready` handshake.
- For loads and stores it issues one request on a 32-bit split request/response data bus and waits for the reply. Loads get their data aligned and extended.
- It then presents the result bundle to writeback through the `m_valid`/`m_ready` handshake.
- Only one instruction is in flight. A bundle with no memory operation passes through in one cycle.

## Interface
Parameters:
- `TIMEOUT`, default 255: maximum number of cycles spent waiting in RESP before the access aborts with a fault; 0 disables the timeout.

Ports:
- `clk`  in  1  clock, rising edge
- `rst`  in  1  asynchronous reset, active-low
- `s_valid` / `s_ready`  in / out  1  upstream handshake
- `mvalidM`, `mwenM`  in  1  memory operation present; operation is a store
- `mwmaskM`  in  8  store byte mask before shifting; only bits [3:0] are used
- `mrtypeM`  in  3  load type (see Structure)
- `src2M`, `ALU_resultM`  in  32  store data; address or ALU result
- `rdregsrcM`, `dnpcM`, `snpcM`, `pcM`, `csraddrM`, `csrM`, `cmp_resultM`, `ecallM`, `rdM`  in  3/32/32/32/12/32/1/1/5  pass-through fields
- `rdregsrcW`, `dnpcW`, `snpcW`, `pcW`, `ALU_resultW`, `csraddrW`, `csrW`, `cmp_resultW`, `ecallW`, `rdW`  out  3/32/32/32/32/12/32/1/1/5  registered copies of the pass-through fields
- `rdataW`  out  32  aligned, extended load data; 0 for stores and for non-memory bundles
- `lsu_faultW`  out  2  fault code: 0 none, 1 misaligned, 2 bus error, 3 timeout
- `m_valid` / `m_ready`  out / in  1  downstream handshake
- `bus_req_valid` / `bus_req_ready`  out / in  1  request handshake
- `bus_req_addr`  out  32  word-aligned address (`ALU_resultM & ~3`)
- `bus_req_wen`  out  1  request is a write
- `bus_req_wdata`, `bus_req_wstrb`  out  32/4  shifted write data and byte strobe
- `bus_resp_valid` / `bus_resp_ready`  in / out  1  response handshake
- `bus_resp_rdata`  in  32  read word
- `bus_resp_err`  in  1  error flag, qualified by `bus_resp_valid`

## Operation
States are IDLE, REQ, RESP and DONE.
- **IDLE:** `s_ready`=1.
  - On `s_valid`, latch the whole bundle.
  - If `mvalidM`=0, go to DONE.
  - If the access is misaligned, go to DONE with fault 1 and no bus request. Misaligned means: halfword with `addr[0]`=1, or word with `addr[1:0]`≠0.
  - Otherwise go to REQ.
- **REQ:** `bus_req_valid`=1. Address, write-enable, data and strobe are held constant. Go to RESP when `bus_req_ready`=1.
- **RESP:** `bus_resp_ready`=1. A wait counter increments each cycle.
  - When `bus_resp_valid`=1: latch the extracted data (loads only), set fault 2 if `bus_resp_err`=1, and go to DONE.
  - When the counter reaches `TIMEOUT` (nonzero): set fault 3, `rdataW`=0, go to DONE.
  - A response arriving after the abort is ignored.
- **DONE:** `m_valid`=1. Return to IDLE on `m_ready`.

Stores:
- Strobe = `mwmaskM[3:0] << addr[1:0]`.
- Write data = `src2M << (8*addr[1:0])`.
- A store completes only after its response (write acknowledge) arrives.

Loads:
- Select the byte or halfword at `addr[1:0]`.
- LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word unchanged.
- Reserved `mrtype` encodings behave as LW.

## Timing
- Non-memory bundle: accepted in cycle 0, `m_valid` asserted in cycle 1.
- Memory access with zero-wait bus: accepted in cycle 0, request in cycle 1, response in cycle 2, `m_valid` in cycle 3.
- Each bus wait cycle adds exactly one cycle.
- Every output comes straight from a register or the state decode; no combinational path from any input to any output.
- Reset, applied asynchronously:
  - State returns to IDLE.
  - All registered outputs and the counter clear to 0.
  - `s_ready`=1; `m_valid`, `bus_req_valid` and `bus_resp_ready` are 0.
- Reset in the middle of an access abandons it. The bus shares the same reset, so no stale response can follow.
- The block never accepts a new bundle before the current one has left DONE, so there is no overlap.

## Structure
- Shared package `lsu_pkg` holds:
  - load type codes: LB=0, LH=1, LW=2, LBU=4, LHU=5;
  - fault codes;
  - state encodings.
- Sub-module `lsu_load_align` (combinational): inputs `rdata`, `addr[1:0]` and `mrtype`; output is the extended 32-bit result.

## Test plan
- **Non-memory bundle:** `mvalidM`=0, `pcM`=0x80000010 → `m_valid` one cycle later; `pcW`=0x80000010, `rdataW`=0; no bus activity.
- **LB sign-extend:** LB at 0x80001003, response 0x80FF_1234 → `bus_req_addr`=0x80001000, `rdataW`=0xFFFFFF80; with LBU the same access gives 0x00000080.
- **SH shift:** SH with `src2M`=0x0000BEEF, `mwmaskM`=0x03, addr 0x...02 → `wstrb`=0xC, `wdata`=0xBEEF0000, `rdataW`=0.
- **Misaligned word:** LW at 0x...01 → no `bus_req_valid`, `m_valid` in cycle 1, `lsu_faultW`=1.
- **Back-pressure:** `bus_req_ready` held low for 3 cycles with the request payload checked stable, then `m_ready` held low for 2 cycles in DONE → outputs stable throughout and `s_ready`=0 until release.
- **Timeout and reset:** with `TIMEOUT`=4 and no response → fault 3 after 4 cycles in RESP. With `rst` pulsed low while in REQ → `bus_req_valid` drops immediately and `s_ready`=1 after release.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the memory-access stage.
//   - load type codes (mrtype)
//   - fault codes reported on lsu_faultW
//   - FSM state encoding
//   - is_misaligned(): alignment rule for a memory access
package lsu_pkg;

   localparam logic [2:0] MRT_LB  = 3'd0;
   localparam logic [2:0] MRT_LH  = 3'd1;
   localparam logic [2:0] MRT_LW  = 3'd2;
   localparam logic [2:0] MRT_LBU = 3'd4;
   localparam logic [2:0] MRT_LHU = 3'd5;

   typedef enum logic [1:0] {
      FAULT_NONE     = 2'd0,
      FAULT_MISALIGN = 2'd1,
      FAULT_BUS      = 2'd2,
      FAULT_TIMEOUT  = 2'd3
   } fault_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_RESP = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   // Loads take their size from mrtype (reserved codes act as word).
   // Stores take it from the byte mask: 4'hF is a word, 4'h3 a halfword,
   // anything else is treated as a byte and has no alignment constraint.
   function automatic logic is_misaligned(input logic       wen,
                                          input logic [3:0] mask,
                                          input logic [2:0] mrtype,
                                          input logic [1:0] addr);
      logic half;
      logic word;
      if (wen) begin
         half = (mask == 4'h3);
         word = (mask == 4'hF);
      end else begin
         half = (mrtype == MRT_LH) || (mrtype == MRT_LHU);
         word = !(half || (mrtype == MRT_LB) || (mrtype == MRT_LBU));
      end
      return (half && addr[0]) || (word && (addr != 2'b00));
   endfunction

endpackage

// File: rtl/mstage_lsu_if.sv
// mstage_lsu_if: split request/response data bus between the LSU and memory.
//   request : bus_req_valid/ready, bus_req_addr, bus_req_wen, bus_req_wdata, bus_req_wstrb
//   response: bus_resp_valid/ready, bus_resp_rdata, bus_resp_err
// Handshake rule for both channels: a beat transfers on a rising clock edge
// where valid and ready are both high; while valid is high and ready is low
// the sender keeps valid asserted and the payload unchanged.
interface mstage_lsu_if;

   logic        bus_req_valid;
   logic        bus_req_ready;
   logic [31:0] bus_req_addr;
   logic        bus_req_wen;
   logic [31:0] bus_req_wdata;
   logic [3:0]  bus_req_wstrb;
   logic        bus_resp_valid;
   logic        bus_resp_ready;
   logic [31:0] bus_resp_rdata;
   logic        bus_resp_err;

   modport master (
      output bus_req_valid, bus_req_addr, bus_req_wen, bus_req_wdata, bus_req_wstrb,
      output bus_resp_ready,
      input  bus_req_ready, bus_resp_valid, bus_resp_rdata, bus_resp_err
   );

   modport slave (
      input  bus_req_valid, bus_req_addr, bus_req_wen, bus_req_wdata, bus_req_wstrb,
      input  bus_resp_ready,
      output bus_req_ready, bus_resp_valid, bus_resp_rdata, bus_resp_err
   );

endinterface

// File: rtl/lsu_load_align.sv
// lsu_load_align: combinational load data extraction.
//   rdata  in  32  word returned by the bus
//   addr   in  2   byte offset of the access
//   mrtype in  3   load type (lsu_pkg MRT_*)
//   data   out 32  selected byte/halfword, sign- or zero-extended; word unchanged
module lsu_load_align
   import lsu_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  addr,
   input  logic [2:0]  mrtype,
   output logic [31:0] data
);

   logic [15:0] shifted;

   assign shifted = 16'(rdata >> {addr, 3'b000});

   always_comb begin
      data = rdata;
      case (mrtype)
         MRT_LB:  data = {{24{shifted[7]}}, shifted[7:0]};
         MRT_LBU: data = {24'd0, shifted[7:0]};
         MRT_LH:  data = {{16{shifted[15]}}, shifted[15:0]};
         MRT_LHU: data = {16'd0, shifted[15:0]};
         default: data = rdata;
      endcase
   end

endmodule

// File: rtl/mstage_lsu.sv
// mstage_lsu: memory-access pipeline stage, one instruction in flight.
//   clk, rst (async, active-low)
//   s_valid/s_ready        : upstream bundle handshake (*M inputs)
//   m_valid/m_ready        : downstream result handshake (*W outputs)
//   bus (master modport)   : split request/response data bus
//   rdataW                 : aligned/extended load data, 0 otherwise
//   lsu_faultW             : 0 none, 1 misaligned, 2 bus error, 3 timeout
//   dbg_state              : current FSM state
// Every output is a register or a decode of the state register.
module mstage_lsu
   import lsu_pkg::*;
#(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        s_valid,
   output logic        s_ready,
   input  logic        mvalidM,
   input  logic        mwenM,
   input  logic [7:0]  mwmaskM,
   input  logic [2:0]  mrtypeM,
   input  logic [31:0] src2M,
   input  logic [31:0] ALU_resultM,
   input  logic [2:0]  rdregsrcM,
   input  logic [31:0] dnpcM,
   input  logic [31:0] snpcM,
   input  logic [31:0] pcM,
   input  logic [11:0] csraddrM,
   input  logic [31:0] csrM,
   input  logic        cmp_resultM,
   input  logic        ecallM,
   input  logic [4:0]  rdM,
   output logic [2:0]  rdregsrcW,
   output logic [31:0] dnpcW,
   output logic [31:0] snpcW,
   output logic [31:0] pcW,
   output logic [31:0] ALU_resultW,
   output logic [11:0] csraddrW,
   output logic [31:0] csrW,
   output logic        cmp_resultW,
   output logic        ecallW,
   output logic [4:0]  rdW,
   output logic [31:0] rdataW,
   output logic [1:0]  lsu_faultW,
   output logic        m_valid,
   input  logic        m_ready,
   mstage_lsu_if.master bus,
   output state_t      dbg_state
);

   localparam int CW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

   state_t        state, state_nxt;
   logic [CW-1:0] wait_cnt;
   logic          mwen_q;
   logic [2:0]    mrtype_q;
   logic [31:0]   req_addr, req_wdata;
   logic          req_wen;
   logic [3:0]    req_wstrb;
   logic          req_valid, resp_ready;
   logic          misalign, timeout_hit;
   logic [31:0]   load_data;
   logic          unused_mask_hi;

   // Only the low nibble of the mask describes a 32-bit bus access.
   assign unused_mask_hi = ^mwmaskM[7:4];

   assign misalign    = is_misaligned(mwenM, mwmaskM[3:0], mrtypeM, ALU_resultM[1:0]);
   assign timeout_hit = (TIMEOUT != 0) && (wait_cnt == CW'(TIMEOUT - 1));

   lsu_load_align u_align (
      .rdata  (bus.bus_resp_rdata),
      .addr   (ALU_resultW[1:0]),
      .mrtype (mrtype_q),
      .data   (load_data)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= ST_IDLE;
         wait_cnt    <= '0;
         mwen_q      <= 1'b0;
         mrtype_q    <= '0;
         req_addr    <= '0;
         req_wen     <= 1'b0;
         req_wdata   <= '0;
         req_wstrb   <= '0;
         rdregsrcW   <= '0;
         dnpcW       <= '0;
         snpcW       <= '0;
         pcW         <= '0;
         ALU_resultW <= '0;
         csraddrW    <= '0;
         csrW        <= '0;
         cmp_resultW <= 1'b0;
         ecallW      <= 1'b0;
         rdW         <= '0;
         rdataW      <= '0;
         lsu_faultW  <= FAULT_NONE;
      end else begin
         state <= state_nxt;
         case (state)
            ST_IDLE: if (s_valid) begin
               rdregsrcW   <= rdregsrcM;
               dnpcW       <= dnpcM;
               snpcW       <= snpcM;
               pcW         <= pcM;
               ALU_resultW <= ALU_resultM;
               csraddrW    <= csraddrM;
               csrW        <= csrM;
               cmp_resultW <= cmp_resultM;
               ecallW      <= ecallM;
               rdW         <= rdM;
               mwen_q      <= mwenM;
               mrtype_q    <= mrtypeM;
               req_addr    <= {ALU_resultM[31:2], 2'b00};
               req_wen     <= mwenM;
               req_wstrb   <= mwmaskM[3:0] << ALU_resultM[1:0];
               req_wdata   <= src2M << {ALU_resultM[1:0], 3'b000};
               rdataW      <= '0;
               wait_cnt    <= '0;
               lsu_faultW  <= (mvalidM && misalign) ? FAULT_MISALIGN : FAULT_NONE;
            end
            ST_RESP: begin
               // A response in the last allowed cycle still wins over the abort.
               if (bus.bus_resp_valid) begin
                  if (!mwen_q) rdataW <= load_data;
                  if (bus.bus_resp_err) lsu_faultW <= FAULT_BUS;
               end else if (timeout_hit) begin
                  lsu_faultW <= FAULT_TIMEOUT;
                  rdataW     <= '0;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_nxt  = state;
      s_ready    = 1'b0;
      m_valid    = 1'b0;
      req_valid  = 1'b0;
      resp_ready = 1'b0;
      case (state)
         ST_IDLE: begin
            s_ready = 1'b1;
            if (s_valid) begin
               if (!mvalidM || misalign) state_nxt = ST_DONE;
               else                      state_nxt = ST_REQ;
            end
         end
         ST_REQ: begin
            req_valid = 1'b1;
            if (bus.bus_req_ready) state_nxt = ST_RESP;
         end
         ST_RESP: begin
            resp_ready = 1'b1;
            if (bus.bus_resp_valid || timeout_hit) state_nxt = ST_DONE;
         end
         ST_DONE: begin
            m_valid = 1'b1;
            if (m_ready) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign bus.bus_req_valid  = req_valid;
   assign bus.bus_req_addr   = req_addr;
   assign bus.bus_req_wen    = req_wen;
   assign bus.bus_req_wdata  = req_wdata;
   assign bus.bus_req_wstrb  = req_wstrb;
   assign bus.bus_resp_ready = resp_ready;
   assign dbg_state          = state;

endmodule

// File: tb/tb_mstage_lsu.sv
// tb_mstage_lsu: directed and randomized checks of mstage_lsu (TIMEOUT=4)
// against a behavioural model of the access rules.
module tb_mstage_lsu;
   import lsu_pkg::*;

   localparam int TO = 4;
   localparam int W  = 216;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        s_valid = 1'b0, s_ready;
   logic        mvalidM = 1'b0, mwenM = 1'b0;
   logic [7:0]  mwmaskM = '0;
   logic [2:0]  mrtypeM = '0;
   logic [31:0] src2M = '0, ALU_resultM = '0;
   logic [2:0]  rdregsrcM = '0;
   logic [31:0] dnpcM = '0, snpcM = '0, pcM = '0, csrM = '0;
   logic [11:0] csraddrM = '0;
   logic        cmp_resultM = 1'b0, ecallM = 1'b0;
   logic [4:0]  rdM = '0;
   logic [2:0]  rdregsrcW;
   logic [31:0] dnpcW, snpcW, pcW, ALU_resultW, csrW, rdataW;
   logic [11:0] csraddrW;
   logic        cmp_resultW, ecallW;
   logic [4:0]  rdW;
   logic [1:0]  lsu_faultW;
   logic        m_valid, m_ready = 1'b0;
   state_t      dbg_state;

   mstage_lsu_if bus_if ();

   mstage_lsu #(.TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
      .mvalidM(mvalidM), .mwenM(mwenM), .mwmaskM(mwmaskM), .mrtypeM(mrtypeM),
      .src2M(src2M), .ALU_resultM(ALU_resultM), .rdregsrcM(rdregsrcM),
      .dnpcM(dnpcM), .snpcM(snpcM), .pcM(pcM), .csraddrM(csraddrM), .csrM(csrM),
      .cmp_resultM(cmp_resultM), .ecallM(ecallM), .rdM(rdM),
      .rdregsrcW(rdregsrcW), .dnpcW(dnpcW), .snpcW(snpcW), .pcW(pcW),
      .ALU_resultW(ALU_resultW), .csraddrW(csraddrW), .csrW(csrW),
      .cmp_resultW(cmp_resultW), .ecallW(ecallW), .rdW(rdW),
      .rdataW(rdataW), .lsu_faultW(lsu_faultW), .m_valid(m_valid), .m_ready(m_ready),
      .bus(bus_if.master), .dbg_state(dbg_state)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   // ---------------- scoreboard state ----------------
   int n_checks = 0;
   int n_fail   = 0;
   logic [W-1:0] exp_q[$];
   logic [31:0]  last_addr, last_wdata, last_rdata;
   logic [3:0]   last_wstrb;
   logic [1:0]   last_fault;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] pack_out(
      input logic [1:0] f, input logic [31:0] rd_data, input logic [31:0] pc,
      input logic [31:0] dnpc, input logic [31:0] snpc, input logic [31:0] alu,
      input logic [31:0] csr, input logic [11:0] csra, input logic [2:0] rds,
      input logic [4:0] rd, input logic cmp, input logic ec);
      return {f, rd_data, pc, dnpc, snpc, alu, csr, csra, rds, rd, cmp, ec};
   endfunction

   function automatic logic [W-1:0] dut_out();
      return pack_out(lsu_faultW, rdataW, pcW, dnpcW, snpcW, ALU_resultW,
                      csrW, csraddrW, rdregsrcW, rdW, cmp_resultW, ecallW);
   endfunction

   task automatic check_bundle(input logic [W-1:0] a, input logic [W-1:0] e);
      check("fault",  64'(a[215:214]), 64'(e[215:214]));
      check("rdata",  64'(a[213:182]), 64'(e[213:182]));
      check("pc",     64'(a[181:150]), 64'(e[181:150]));
      check("dnpc",   64'(a[149:118]), 64'(e[149:118]));
      check("snpc",   64'(a[117:86]),  64'(e[117:86]));
      check("alu",    64'(a[85:54]),   64'(e[85:54]));
      check("csr",    64'(a[53:22]),   64'(e[53:22]));
      check("misc",   64'(a[21:0]),    64'(e[21:0]));
   endtask

   // ---------------- driver tasks ----------------
   task automatic scramble();
      mvalidM = 1'($urandom); mwenM = 1'($urandom); mwmaskM = 8'($urandom);
      mrtypeM = 3'($urandom); src2M = $urandom; ALU_resultM = $urandom;
      pcM = $urandom; dnpcM = $urandom; snpcM = $urandom; csrM = $urandom;
      csraddrM = 12'($urandom); rdregsrcM = 3'($urandom); rdM = 5'($urandom);
      cmp_resultM = 1'($urandom); ecallM = 1'($urandom);
   endtask

   // Called on a falling edge with the DUT idle; returns on a falling edge idle.
   task automatic do_txn(input bit mv, input bit wen, input logic [7:0] mask,
                         input logic [2:0] rt, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] resp,
                         input bit err, input bit no_resp, input int req_wait,
                         input int resp_wait, input int out_wait,
                         input logic [31:0] pc);
      int off, size, cnt;
      bit use_bus;
      logic [31:0] e_rdata, e_strb, e_wdata, b, h;
      logic [1:0]  e_fault;
      logic [W-1:0] e;

      // reference model
      off = int'(addr[1:0]);
      if (wen) size = (mask[3:0] == 4'hF) ? 4 : (mask[3:0] == 4'h3) ? 2 : 1;
      else begin
         case (rt)
            3'd0, 3'd4: size = 1;
            3'd1, 3'd5: size = 2;
            default:    size = 4;
         endcase
      end
      e_fault = 2'd0; e_rdata = '0; e_strb = '0; e_wdata = '0; use_bus = 0;
      if (mv && (off % size != 0)) e_fault = 2'd1;
      else if (mv) begin
         use_bus = 1;
         e_strb  = (32'(mask[3:0]) << off) % 16;
         e_wdata = wd << (8 * off);
         if (no_resp) e_fault = 2'd3;
         else begin
            if (err) e_fault = 2'd2;
            if (!wen) begin
               b = (resp >> (8 * off)) % 256;
               h = (resp >> (8 * off)) % 65536;
               case (rt)
                  3'd0:    e_rdata = (b >= 128) ? b - 256 : b;
                  3'd4:    e_rdata = b;
                  3'd1:    e_rdata = (h >= 32768) ? h - 65536 : h;
                  3'd5:    e_rdata = h;
                  default: e_rdata = resp;
               endcase
            end
         end
      end

      // present the bundle
      mvalidM = mv; mwenM = wen; mwmaskM = mask; mrtypeM = rt; src2M = wd;
      ALU_resultM = addr; pcM = pc; dnpcM = $urandom; snpcM = $urandom;
      csrM = $urandom; csraddrM = 12'($urandom); rdregsrcM = 3'($urandom);
      rdM = 5'($urandom); cmp_resultM = 1'($urandom); ecallM = 1'($urandom);
      e = pack_out(e_fault, e_rdata, pc, dnpcM, snpcM, addr, csrM, csraddrM,
                   rdregsrcM, rdM, cmp_resultM, ecallM);
      exp_q.push_back(e);
      s_valid = 1'b1;
      check("s_ready_idle", 64'(s_ready), 64'd1);
      @(negedge clk);
      s_valid = 1'b0;
      scramble();

      if (use_bus) begin
         for (int i = 0; i < req_wait; i++) begin
            check("req_valid_hold", 64'(bus_if.bus_req_valid), 64'd1);
            check("req_addr_hold", 64'(bus_if.bus_req_addr), 64'(addr - off));
            if (wen) check("req_wdata_hold", 64'(bus_if.bus_req_wdata), 64'(e_wdata));
            check("s_ready_busy", 64'(s_ready), 64'd0);
            @(negedge clk);
         end
         bus_if.bus_req_ready = 1'b1;
         check("req_valid", 64'(bus_if.bus_req_valid), 64'd1);
         check("req_addr", 64'(bus_if.bus_req_addr), 64'(addr - off));
         check("req_wen", 64'(bus_if.bus_req_wen), 64'(wen));
         if (wen) begin
            check("req_wstrb", 64'(bus_if.bus_req_wstrb), 64'(e_strb));
            check("req_wdata", 64'(bus_if.bus_req_wdata), 64'(e_wdata));
         end
         last_addr = bus_if.bus_req_addr;
         last_wstrb = bus_if.bus_req_wstrb;
         last_wdata = bus_if.bus_req_wdata;
         @(negedge clk);
         bus_if.bus_req_ready = 1'b0;
         check("req_drop", 64'(bus_if.bus_req_valid), 64'd0);
         if (no_resp) begin
            cnt = 0;
            while (!m_valid && cnt < TO + 6) begin
               check("resp_ready_wait", 64'(bus_if.bus_resp_ready), 64'd1);
               cnt++;
               @(negedge clk);
            end
            check("timeout_cycles", 64'(cnt), 64'(TO));
         end else begin
            for (int i = 0; i < resp_wait; i++) begin
               check("resp_ready_wait", 64'(bus_if.bus_resp_ready), 64'd1);
               check("m_valid_early", 64'(m_valid), 64'd0);
               @(negedge clk);
            end
            bus_if.bus_resp_valid = 1'b1;
            bus_if.bus_resp_rdata = resp;
            bus_if.bus_resp_err   = err;
            check("resp_ready", 64'(bus_if.bus_resp_ready), 64'd1);
            @(negedge clk);
            bus_if.bus_resp_valid = 1'b0;
            bus_if.bus_resp_err   = 1'b0;
         end
      end else begin
         check("no_req", 64'(bus_if.bus_req_valid), 64'd0);
      end

      // result phase, with optional downstream back-pressure
      for (int i = 0; i < out_wait; i++) begin
         if (no_resp) begin
            bus_if.bus_resp_valid = 1'b1;
            bus_if.bus_resp_rdata = $urandom;
            bus_if.bus_resp_err   = 1'($urandom);
         end
         check("m_valid_hold", 64'(m_valid), 64'd1);
         check("s_ready_hold", 64'(s_ready), 64'd0);
         check("rdata_hold", 64'(rdataW), 64'(e_rdata));
         check("fault_hold", 64'(lsu_faultW), 64'(e_fault));
         @(negedge clk);
      end
      bus_if.bus_resp_valid = 1'b0;
      bus_if.bus_resp_err   = 1'b0;
      m_ready = 1'b1;
      check("m_valid", 64'(m_valid), 64'd1);
      check_bundle(dut_out(), exp_q.pop_front());
      last_rdata = rdataW;
      last_fault = lsu_faultW;
      @(negedge clk);
      m_ready = 1'b0;
      check("m_valid_drop", 64'(m_valid), 64'd0);
      check("s_ready_back", 64'(s_ready), 64'd1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check(tag, 64'({s_ready, m_valid, bus_if.bus_req_valid, bus_if.bus_resp_ready}), 64'b1000);
      check("rst_pcW", 64'(pcW), 64'd0);
      check("rst_rdataW", 64'(rdataW), 64'd0);
      check("rst_faultW", 64'(lsu_faultW), 64'd0);
      check("rst_req_addr", 64'(bus_if.bus_req_addr), 64'd0);
   endtask

   task automatic reset_in_req();
      mvalidM = 1'b1; mwenM = 1'b0; mrtypeM = MRT_LW; ALU_resultM = 32'h8000_4000;
      pcM = 32'h8000_0abc; s_valid = 1'b1;
      @(negedge clk);
      s_valid = 1'b0;
      check("rr_in_req", 64'(bus_if.bus_req_valid), 64'd1);
      #2 rst = 1'b0;
      #1 check_reset_outputs("rr_async");
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("rr_after", 64'({s_ready, bus_if.bus_req_valid}), 64'b10);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      bus_if.bus_req_ready = 1'b0;
      bus_if.bus_resp_valid = 1'b0;
      bus_if.bus_resp_rdata = '0;
      bus_if.bus_resp_err = 1'b0;
      repeat (2) @(negedge clk);
      check_reset_outputs("reset_state");
      rst = 1'b1;
      @(negedge clk);

      // non-memory bundle
      do_txn(0, 0, 8'h00, 3'd0, 32'h1234_5678, '0, '0, 0, 0, 0, 0, 0, 32'h8000_0010);
      check("nomem_rdata", 64'(last_rdata), 64'd0);

      // LB / LBU at byte 3
      do_txn(1, 0, 8'h00, MRT_LB, 32'h8000_1003, '0, 32'h80FF_1234, 0, 0, 0, 0, 0, $urandom);
      check("lb_addr", 64'(last_addr), 64'h8000_1000);
      check("lb_data", 64'(last_rdata), 64'hFFFF_FF80);
      do_txn(1, 0, 8'h00, MRT_LBU, 32'h8000_1003, '0, 32'h80FF_1234, 0, 0, 0, 0, 0, $urandom);
      check("lbu_data", 64'(last_rdata), 64'h0000_0080);

      // SH at halfword 2
      do_txn(1, 1, 8'h03, MRT_LH, 32'h8000_2002, 32'h0000_BEEF, $urandom, 0, 0, 0, 0, 0, $urandom);
      check("sh_wstrb", 64'(last_wstrb), 64'hC);
      check("sh_wdata", 64'(last_wdata), 64'hBEEF_0000);
      check("sh_rdata", 64'(last_rdata), 64'd0);

      // misaligned word load
      do_txn(1, 0, 8'h00, MRT_LW, 32'h8000_3001, '0, '0, 0, 0, 0, 0, 0, $urandom);
      check("misalign_fault", 64'(last_fault), 64'd1);

      // back-pressure on request and result
      do_txn(1, 0, 8'h00, MRT_LW, 32'h8000_5008, '0, 32'hCAFE_F00D, 0, 0, 3, 1, 2, $urandom);
      check("bp_rdata", 64'(last_rdata), 64'hCAFE_F00D);

      // bus error and timeout (late response ignored)
      do_txn(1, 0, 8'h00, MRT_LHU, 32'h8000_6002, '0, 32'h9876_5432, 1, 0, 0, 0, 0, $urandom);
      check("err_fault", 64'(last_fault), 64'd2);
      do_txn(1, 0, 8'h00, MRT_LW, 32'h8000_7004, '0, '0, 0, 1, 0, 0, 2, $urandom);
      check("timeout_fault", 64'(last_fault), 64'd3);
      // response on the final allowed RESP cycle is still taken
      do_txn(1, 1, 8'h0F, MRT_LW, 32'h8000_7008, $urandom, '0, 0, 0, 0, TO - 1, 0, $urandom);
      check("late_ok_fault", 64'(last_fault), 64'd0);

      reset_in_req();

      // randomized traffic
      for (int n = 0; n < 150; n++) begin
         logic [3:0] lo;
         case ($urandom_range(0, 3))
            0: lo = 4'h1;
            1: lo = 4'h3;
            2: lo = 4'hF;
            default: lo = 4'($urandom);
         endcase
         do_txn($urandom_range(0, 9) != 0, 1'($urandom), {4'($urandom), lo},
                3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
                $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0,
                $urandom_range(0, 2), $urandom_range(0, TO - 1),
                $urandom_range(0, 2), $urandom);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      n_fail++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
